writeback_mc: RTL and testbench
===============================

# writeback_mc

Multi-channel writeback stage for the Orion RV32 core. It accepts completed results from `NUM_CH` independent execution channels (e.g. ALU/CSR, load, mul/div) over valid/ready handshakes and arbitrates them onto the single register-file write port. It presents that write port, registered, to the decode/regfile stage, and reports per-cycle retirement counts to the CSR file for `minstret`. It replaces the single-channel combinational writeback once out-of-order-completing units are added.

## Interface
- `NUM_CH`, 3: number of result channels; must be at least 1.
- `XLEN`, 32: data width.
- `RF_IDX_BITS`, 5: register index width.
- `ARB_MODE`, 0: 0 selects round-robin, 1 selects fixed priority (channel 0 highest).
- `CNT_W`, `$clog2(NUM_CH+1)`: width of the retire count (derived, not overridden).

Ports:
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  reset; asynchronous, active-high.
- `ch_valid_i`  in  [NUM_CH]  channel i holds a completed instruction.
- `ch_ready_o`  out  [NUM_CH]  channel i's result is accepted this cycle.
- `ch_rd_we_i`  in  [NUM_CH]  result writes rd.
- `ch_rd_s_i`  in  [NUM_CH][RF_IDX_BITS]  destination register index.
- `ch_rd_v_i`  in  [NUM_CH][XLEN]  result value.
- `wb_rd_we_o`  out  1  registered regfile write enable.
- `wb_rd_s_o`  out  RF_IDX_BITS  registered write index.
- `wb_rd_v_o`  out  XLEN  registered write data.
- `retire_cnt_o`  out  CNT_W  instructions retired in the previous cycle; feeds CSR `instr_retired`.

## Operation
- A channel is *writing* when `ch_valid_i & ch_rd_we_i & (ch_rd_s_i != 0)`. It is *non-writing* when valid but not writing; this includes writes to x0.
- Non-writing channels are always accepted: `ch_ready_o[i]=1` in the same cycle, with no arbitration. All non-writing channels retire together.
- Writing channels compete for one grant per cycle:
  - Round-robin (`ARB_MODE=0`): search upward from `rr_ptr`, wrapping. After a grant, `rr_ptr` becomes grant index + 1, wrapping from NUM_CH-1 to 0. With no grant, `rr_ptr` is unchanged.
  - Fixed priority (`ARB_MODE=1`): the lowest writing index wins, and `rr_ptr` is unused.
- `ch_ready_o[i]=1` for the granted writing channel. `ch_ready_o[i]=0` for ungranted writing channels and for channels that are not valid.
- `ch_ready_o` is combinational from `ch_valid_i`, `ch_rd_we_i`, `ch_rd_s_i` and `rr_ptr`.
- Handshake rules for channels:
  - A channel must not derive its valid from ready.
  - Once valid is asserted, valid, rd_we, rd_s and rd_v must stay stable until accepted.
- Retire count: the next `retire_cnt_o` equals the popcount of `ch_valid_i & ch_ready_o`, at most NUM_CH.
- The block never resolves same-rd hazards; the upstream scoreboard guarantees that no two in-flight channels target the same rd.

## Timing
- Latency is one cycle: a handshake in cycle N produces `wb_*` and `retire_cnt_o` in cycle N+1.
- With no grant in cycle N, `wb_rd_we_o=0` in N+1, and `wb_rd_s_o`/`wb_rd_v_o` hold their previous values.
- A writing channel that loses arbitration stalls. In round-robin mode, any continuously valid writer is granted within NUM_CH cycles.
- Reset values: `wb_rd_we_o=0`, `wb_rd_s_o=0`, `wb_rd_v_o=0`, `retire_cnt_o=0`, `rr_ptr=0`.
- Reset asserted mid-operation clears all of these immediately, regardless of clock. Handshakes during reset are not counted.
- `ch_ready_o` is all-zero while `rst_i=1`.
- With `NUM_CH=1`, `rr_ptr` is constant 0, and the single writer is granted every cycle it is valid.

## Structure
- Add to `orion_types`: the `wb_ch_t` struct {rd_we, rd_s, rd_v} and the `wb_arb_mode_e` enum {WB_ARB_RR, WB_ARB_FIXED}. Existing `XLEN`/`RF_IDX_BITS` are reused.
- Sub-module `rr_arbiter`: parameters N and MODE; inputs req[N] and ptr; outputs a one-hot grant and a grant_valid. Pointer update stays in `writeback_mc`.
- `writeback_mc` contains the writing/non-writing classification, the output register, the popcount and the pointer register.

## Test plan
- Reset sequence: assert `rst_i` asynchronously between clock edges -> all outputs and `ch_ready_o` are 0 immediately. Release reset, then ch0 writes x5=0xDEADBEEF -> next cycle `wb_rd_we_o=1`, `wb_rd_s_o=5`, `wb_rd_v_o=0xDEADBEEF`, `retire_cnt_o=1`.
- Round-robin, NUM_CH=3, all three channels writing x1/x2/x3 and held valid -> grants 0,1,2 in consecutive cycles. `wb_rd_s_o` sequence is 1,2,3. `retire_cnt_o` is 1 each cycle.
- Mixed cycle: ch0 rd_we=0, ch1 writes x0, ch2 writes x7=0x42 -> all three ready in the same cycle. Next cycle `wb_rd_s_o=7`, `wb_rd_v_o=0x42`, `retire_cnt_o=3`.
- Fixed priority (`ARB_MODE=1`): ch0 and ch2 continuously writing for 4 cycles -> ch0 is granted all 4 cycles, and ch2's ready stays 0.
- Wrap-around: `rr_ptr=2`, ch0 and ch1 writing -> ch0 is granted and `rr_ptr` becomes 1.
- Reset mid-stall: ch1 stalled with rr_ptr=2 -> assert reset -> `rr_ptr=0` and `wb_rd_we_o=0`. After release, ch1 is granted in the first cycle. A bench assertion checks valid/data stability until ready.

Source files
------------

// File: rtl/orion_types.sv
// orion_types: shared Orion RV32 core widths and writeback-stage types.
package orion_types;
    localparam int XLEN        = 32;
    localparam int RF_IDX_BITS = 5;

    typedef enum logic {
        WB_ARB_RR    = 1'b0,
        WB_ARB_FIXED = 1'b1
    } wb_arb_mode_e;

    typedef struct packed {
        logic                   rd_we;
        logic [RF_IDX_BITS-1:0] rd_s;
        logic [XLEN-1:0]        rd_v;
    } wb_ch_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: one-hot grant among N requesters, rotating from ptr_i or fixed lowest-index-first.
module rr_arbiter import orion_types::*; #(
    parameter int           N    = 3,
    parameter wb_arb_mode_e MODE = WB_ARB_RR,
    localparam int          PW   = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic          gnt_valid_o
);
    logic [PW-1:0] idx;
    logic          found;

    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            idx = (MODE == WB_ARB_FIXED) ? PW'(k) : PW'((int'(ptr_i) + k) % N);
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

    assign gnt_valid_o = |req_i;
endmodule

// File: rtl/writeback_mc.sv
// writeback_mc: arbitrates completed results from NUM_CH channels onto the single
// regfile write port (registered) and reports per-cycle retirement counts.
module writeback_mc import orion_types::wb_arb_mode_e, orion_types::WB_ARB_RR, orion_types::WB_ARB_FIXED; #(
    parameter int  NUM_CH      = 3,
    parameter int  XLEN        = 32,
    parameter int  RF_IDX_BITS = 5,
    parameter int  ARB_MODE    = 0,
    localparam int CNT_W       = $clog2(NUM_CH + 1)
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic [NUM_CH-1:0]                  ch_valid_i,
    output logic [NUM_CH-1:0]                  ch_ready_o,
    input  logic [NUM_CH-1:0]                  ch_rd_we_i,
    input  logic [NUM_CH-1:0][RF_IDX_BITS-1:0] ch_rd_s_i,
    input  logic [NUM_CH-1:0][XLEN-1:0]        ch_rd_v_i,
    output logic                               wb_rd_we_o,
    output logic [RF_IDX_BITS-1:0]             wb_rd_s_o,
    output logic [XLEN-1:0]                    wb_rd_v_o,
    output logic [CNT_W-1:0]                   retire_cnt_o
);
    localparam int           PW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam wb_arb_mode_e MODE = (ARB_MODE == 1) ? WB_ARB_FIXED : WB_ARB_RR;

    logic [NUM_CH-1:0]      writing, non_writing, gnt, ready;
    logic                   gnt_valid;
    logic [PW-1:0]          rr_ptr_q, rr_ptr_d, gnt_idx;
    logic [RF_IDX_BITS-1:0] sel_s, wb_rd_s_q, wb_rd_s_d;
    logic [XLEN-1:0]        sel_v, wb_rd_v_q, wb_rd_v_d;
    logic                   wb_rd_we_q, wb_rd_we_d;
    logic [CNT_W-1:0]       retire_cnt_q, retire_cnt_d;

    // Writes to x0 are discarded, so they retire without touching the port.
    always_comb begin
        writing = '0;
        for (int i = 0; i < NUM_CH; i++)
            writing[i] = ch_valid_i[i] & ch_rd_we_i[i] & (|ch_rd_s_i[i]);
    end

    assign non_writing = ch_valid_i & ~writing;

    rr_arbiter #(
        .N    (NUM_CH),
        .MODE (MODE)
    ) u_arb (
        .req_i       (writing),
        .ptr_i       (rr_ptr_q),
        .gnt_o       (gnt),
        .gnt_valid_o (gnt_valid)
    );

    assign ready      = rst_i ? '0 : (non_writing | gnt);
    assign ch_ready_o = ready;

    always_comb begin
        sel_s   = '0;
        sel_v   = '0;
        gnt_idx = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (gnt[i]) begin
                sel_s   = ch_rd_s_i[i];
                sel_v   = ch_rd_v_i[i];
                gnt_idx = PW'(i);
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (MODE == WB_ARB_RR && gnt_valid)
            rr_ptr_d = (gnt_idx == PW'(NUM_CH - 1)) ? '0 : gnt_idx + 1'b1;
        wb_rd_we_d   = gnt_valid;
        wb_rd_s_d    = gnt_valid ? sel_s : wb_rd_s_q;
        wb_rd_v_d    = gnt_valid ? sel_v : wb_rd_v_q;
        retire_cnt_d = '0;
        for (int i = 0; i < NUM_CH; i++)
            retire_cnt_d = retire_cnt_d + CNT_W'(ch_valid_i[i] & ready[i]);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_ptr_q     <= '0;
            wb_rd_we_q   <= 1'b0;
            wb_rd_s_q    <= '0;
            wb_rd_v_q    <= '0;
            retire_cnt_q <= '0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            wb_rd_we_q   <= wb_rd_we_d;
            wb_rd_s_q    <= wb_rd_s_d;
            wb_rd_v_q    <= wb_rd_v_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

    assign wb_rd_we_o   = wb_rd_we_q;
    assign wb_rd_s_o    = wb_rd_s_q;
    assign wb_rd_v_o    = wb_rd_v_q;
    assign retire_cnt_o = retire_cnt_q;
endmodule

// File: tb/tb_writeback_mc.sv
// tb_writeback_mc: directed vectors for writeback_mc in round-robin and fixed-priority modes.
module tb_writeback_mc;
    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [2:0]        vld, we;
    logic [2:0][4:0]   s;
    logic [2:0][31:0]  v;
    logic [2:0]        rdy, rdy_fx;
    logic              owe, owe_fx;
    logic [4:0]        os, os_fx;
    logic [31:0]       ov, ov_fx;
    logic [1:0]        cnt, cnt_fx;
    int                checks = 0;
    int                errors = 0;

    always #5 clk = ~clk;

    writeback_mc #(.NUM_CH(3), .XLEN(32), .RF_IDX_BITS(5), .ARB_MODE(0)) dut (
        .clk_i(clk), .rst_i(rst), .ch_valid_i(vld), .ch_ready_o(rdy), .ch_rd_we_i(we),
        .ch_rd_s_i(s), .ch_rd_v_i(v), .wb_rd_we_o(owe), .wb_rd_s_o(os), .wb_rd_v_o(ov),
        .retire_cnt_o(cnt)
    );

    writeback_mc #(.NUM_CH(3), .XLEN(32), .RF_IDX_BITS(5), .ARB_MODE(1)) dut_fx (
        .clk_i(clk), .rst_i(rst), .ch_valid_i(vld), .ch_ready_o(rdy_fx), .ch_rd_we_i(we),
        .ch_rd_s_i(s), .ch_rd_v_i(v), .wb_rd_we_o(owe_fx), .wb_rd_s_o(os_fx), .wb_rd_v_o(ov_fx),
        .retire_cnt_o(cnt_fx)
    );

    typedef struct {
        logic [2:0]       vld, we;
        logic [2:0][4:0]  s;
        logic [2:0][31:0] v;
        logic [2:0]       rdy;
        logic             owe;
        logic [4:0]       os;
        logic [31:0]      ov;
        logic [1:0]       cnt;
    } vec_t;

    vec_t tbl[14];

    function automatic vec_t mk(input logic [2:0] vl, w, input logic [14:0] ss, input logic [95:0] dd,
                                input logic [2:0] r, input logic oe, input logic [4:0] o_s,
                                input logic [31:0] o_v, input logic [1:0] c);
        vec_t t;
        t.vld = vl; t.we = w; t.s = ss; t.v = dd; t.rdy = r;
        t.owe = oe; t.os = o_s; t.ov = o_v; t.cnt = c;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_out(input string name, input logic e_we, input logic [4:0] e_s,
                             input logic [31:0] e_v, input logic [1:0] e_c);
        chk({name, "_we"}, 32'(owe), 32'(e_we));
        chk({name, "_s"}, 32'(os), 32'(e_s));
        chk({name, "_v"}, ov, e_v);
        chk({name, "_cnt"}, 32'(cnt), 32'(e_c));
    endtask

    task automatic drive(input logic [2:0] vl, w, input logic [14:0] ss, input logic [95:0] dd);
        vld = vl; we = w; s = ss; v = dd;
    endtask

    // Channel protocol: once valid and not accepted, the request must stay put.
    logic [2:0]       pend = '0;
    logic [2:0]       pwe;
    logic [2:0][4:0]  ps;
    logic [2:0][31:0] pv;
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst && pend[i]) begin
                checks++;
                if (!(vld[i] === 1'b1 && we[i] === pwe[i] && s[i] === ps[i] && v[i] === pv[i])) begin
                    errors++;
                    $display("FAIL hold_ch%0d: got vld=%b s=%0d v=0x%0h, expected held s=%0d v=0x%0h",
                             i, vld[i], s[i], v[i], ps[i], pv[i]);
                end
            end
        end
        pend <= rst ? 3'b000 : (vld & ~rdy);
        pwe  <= we;
        ps   <= s;
        pv   <= v;
    end

    initial begin
        tbl[0]  = mk(3'b001, 3'b001, {5'd0, 5'd0, 5'd5}, {32'h0, 32'h0, 32'hDEADBEEF}, 3'b001, 1'b1, 5'd5, 32'hDEADBEEF, 2'd1);
        tbl[1]  = mk(3'b100, 3'b100, {5'd9, 5'd0, 5'd0}, {32'h99, 32'h0, 32'h0}, 3'b100, 1'b1, 5'd9, 32'h99, 2'd1);
        tbl[2]  = mk(3'b111, 3'b111, {5'd3, 5'd2, 5'd1}, {32'h33, 32'h22, 32'h11}, 3'b001, 1'b1, 5'd1, 32'h11, 2'd1);
        tbl[3]  = mk(3'b111, 3'b111, {5'd3, 5'd2, 5'd1}, {32'h33, 32'h22, 32'h11}, 3'b010, 1'b1, 5'd2, 32'h22, 2'd1);
        tbl[4]  = mk(3'b111, 3'b111, {5'd3, 5'd2, 5'd1}, {32'h33, 32'h22, 32'h11}, 3'b100, 1'b1, 5'd3, 32'h33, 2'd1);
        tbl[5]  = mk(3'b011, 3'b011, {5'd0, 5'd2, 5'd1}, {32'h0, 32'h22, 32'h11}, 3'b001, 1'b1, 5'd1, 32'h11, 2'd1);
        tbl[6]  = mk(3'b010, 3'b010, {5'd0, 5'd2, 5'd0}, {32'h0, 32'h22, 32'h0}, 3'b010, 1'b1, 5'd2, 32'h22, 2'd1);
        tbl[7]  = mk(3'b000, 3'b000, 15'd0, 96'd0, 3'b000, 1'b0, 5'd2, 32'h22, 2'd0);
        tbl[8]  = mk(3'b111, 3'b110, {5'd7, 5'd0, 5'd4}, {32'h42, 32'h55, 32'h44}, 3'b111, 1'b1, 5'd7, 32'h42, 2'd3);
        tbl[9]  = mk(3'b010, 3'b010, {5'd0, 5'd6, 5'd0}, {32'h0, 32'h66, 32'h0}, 3'b010, 1'b1, 5'd6, 32'h66, 2'd1);
        tbl[10] = mk(3'b011, 3'b011, {5'd0, 5'd2, 5'd1}, {32'h0, 32'h202, 32'h101}, 3'b001, 1'b1, 5'd1, 32'h101, 2'd1);
        tbl[11] = mk(3'b011, 3'b011, {5'd0, 5'd2, 5'd3}, {32'h0, 32'h202, 32'h303}, 3'b010, 1'b1, 5'd2, 32'h202, 2'd1);
        tbl[12] = mk(3'b001, 3'b001, {5'd0, 5'd0, 5'd3}, {32'h0, 32'h0, 32'h303}, 3'b001, 1'b1, 5'd3, 32'h303, 2'd1);
        tbl[13] = mk(3'b000, 3'b000, 15'd0, 96'd0, 3'b000, 1'b0, 5'd3, 32'h303, 2'd0);

        // Non-writing requests would be ready at once if reset did not mask them.
        drive(3'b111, 3'b000, {5'd3, 5'd2, 5'd1}, 96'd0);
        #3 rst = 1'b1;
        #1;
        check_out("reset", 1'b0, 5'd0, 32'h0, 2'd0);
        chk("reset_rdy", 32'(rdy), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        drive(3'b000, 3'b000, 15'd0, 96'd0);

        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].vld, tbl[i].we, tbl[i].s, tbl[i].v);
            #1 chk($sformatf("vec%0d_rdy", i), 32'(rdy), 32'(tbl[i].rdy));
            @(posedge clk);
            #1 check_out($sformatf("vec%0d", i), tbl[i].owe, tbl[i].os, tbl[i].ov, tbl[i].cnt);
            @(negedge clk);
        end

        // Stall ch1 behind ch2 with the pointer at 2, then reset mid-cycle.
        drive(3'b010, 3'b010, {5'd0, 5'd6, 5'd0}, {32'h0, 32'h66, 32'h0});
        @(posedge clk);
        #1 check_out("stall_pre", 1'b1, 5'd6, 32'h66, 2'd1);
        @(negedge clk);
        drive(3'b110, 3'b110, {5'd9, 5'd8, 5'd0}, {32'h99, 32'h88, 32'h0});
        #1 chk("stall_rdy", 32'(rdy), 32'b100);
        #1 rst = 1'b1;
        #1;
        check_out("midrst", 1'b0, 5'd0, 32'h0, 2'd0);
        chk("midrst_rdy", 32'(rdy), 32'h0);
        @(posedge clk);
        #1 check_out("inrst", 1'b0, 5'd0, 32'h0, 2'd0);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("postrst_rdy", 32'(rdy), 32'b010);
        @(posedge clk);
        #1 check_out("postrst", 1'b1, 5'd8, 32'h88, 2'd1);
        @(negedge clk);
        drive(3'b100, 3'b100, {5'd9, 5'd0, 5'd0}, {32'h99, 32'h0, 32'h0});
        #1 chk("drain_rdy", 32'(rdy), 32'b100);
        @(posedge clk);
        #1 check_out("drain", 1'b1, 5'd9, 32'h99, 2'd1);
        @(negedge clk);

        // Fixed priority: ch0 keeps winning, ch2 never sees ready.
        drive(3'b101, 3'b101, {5'd3, 5'd0, 5'd1}, {32'hC, 32'h0, 32'hA});
        for (int c = 0; c < 4; c++) begin
            #1 chk($sformatf("fx%0d_rdy", c), 32'(rdy_fx), 32'b001);
            @(posedge clk);
            #1;
            chk($sformatf("fx%0d_we", c), 32'(owe_fx), 32'h1);
            chk($sformatf("fx%0d_s", c), 32'(os_fx), 32'd1);
            chk($sformatf("fx%0d_v", c), ov_fx, 32'hA);
            chk($sformatf("fx%0d_cnt", c), 32'(cnt_fx), 32'd1);
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
